// File: rtl/nes_pkg.sv
// Shared types and constants for the NES gamepad poll controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nes_pkg;

   localparam int NES_BITS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } nes_state_t;

endpackage

// File: rtl/nes_phase_timer.sv
// Divide counter splitting a serial slot into 2*DIV phases with strobes.
// Latency: phase is 0 on the cycle after clr, strobes are combinational.
// Backpressure: none; free-running unless cleared.
module nes_phase_timer #(
   parameter int DIV = 6
) (
   input  logic core_clk,
   input  logic arst_n,
   input  logic clr,
   output logic last_low,
   output logic slot_end
);

   localparam int PW = $clog2(2 * DIV);

   logic [PW-1:0] phase;

   assign last_low = (phase == PW'(DIV - 1));
   assign slot_end = (phase == PW'(2 * DIV - 1));

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         phase <= '0;
      end else if (clr || slot_end) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

endmodule

// File: rtl/nes_poll_controller.sv
// Polls an NES gamepad: latch pulse, 8 serial clocks, sample, publish byte.
// Latency: trigger at T gives valid at T+18*DIV+1; next trigger at T+18*DIV+2.
// Backpressure: none; triggers arriving while busy are dropped, not queued.
module nes_poll_controller
   import nes_pkg::*;
#(
   parameter int DIV         = 6,
   parameter int POLL_CYCLES = 833333
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                en,
   input  logic                start,
   input  logic                nes_data,
   output logic                nes_latch,
   output logic                nes_clk,
   output logic [NES_BITS-1:0] buttons,
   output logic [NES_BITS-1:0] pressed,
   output logic                valid,
   output logic                busy
);

   localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   generate
      if (DIV < 2) begin : g_bad_div
         $error("nes_poll_controller: DIV must be at least 2");
      end
      if (POLL_CYCLES <= 18 * DIV + 2) begin : g_bad_poll
         $error("nes_poll_controller: POLL_CYCLES must exceed one frame (18*DIV+2)");
      end
   endgenerate

   nes_state_t          state;
   logic [TW-1:0]       poll_cnt;
   logic                tick;
   logic [2:0]          bit_idx;
   logic [NES_BITS-1:0] shift_q;
   logic                phase_clr;
   logic                last_low;
   logic                slot_end;

   assign tick = (poll_cnt == TW'(POLL_CYCLES - 1));

   // Phase restarts on entry to LATCH and READ; READ slots then wrap on their own.
   assign phase_clr = !en || (state == IDLE) || ((state == LATCH) && slot_end);

   nes_phase_timer #(
      .DIV (DIV)
   ) u_phase (
      .core_clk (CLK),
      .arst_n   (reset),
      .clr      (phase_clr),
      .last_low (last_low),
      .slot_end (slot_end)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         poll_cnt <= '0;
      end else if (!en || tick) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + TW'(1);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         nes_latch <= 1'b0;
         nes_clk   <= 1'b1;
         buttons   <= '0;
         pressed   <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         bit_idx   <= '0;
         shift_q   <= '0;
      end else begin
         valid <= 1'b0;
         if (!en) begin
            // Abort: pins back to idle levels, published state untouched.
            state     <= IDLE;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (tick || start) begin
                     state     <= LATCH;
                     nes_latch <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
               LATCH: begin
                  if (slot_end) begin
                     state     <= READ;
                     nes_latch <= 1'b0;
                     nes_clk   <= 1'b0;
                     bit_idx   <= '0;
                  end
               end
               READ: begin
                  if (last_low) begin
                     shift_q[bit_idx] <= ~nes_data;
                     nes_clk          <= 1'b1;
                  end
                  if (slot_end) begin
                     if (bit_idx == 3'd7) begin
                        state   <= DONE;
                        buttons <= shift_q;
                        pressed <= shift_q & ~buttons;
                        valid   <= 1'b1;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        nes_clk <= 1'b0;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
